// File: rtl/mlp_train_scheduler.sv
// Sequences MLP training: presents each sample for SETTLE_CYCLES, then pulses mlp_training once.
// Run length num_epochs*NUM_SAMPLES*(SETTLE_CYCLES+1) cycles; no backpressure, abort/rst preempt.
module mlp_train_scheduler #(
    parameter int NUM_SAMPLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int DECAY_EPOCHS  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [15:0]                    num_epochs,
    input  real                            lr_init,
    output logic [$clog2(NUM_SAMPLES)-1:0] sample_idx,
    output logic                           mlp_training,
    output real                            mlp_learning_rate,
    output logic [15:0]                    epoch_count,
    output logic                           busy,
    output logic                           done
);

    localparam int SW = $clog2(NUM_SAMPLES);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYCLES - 1);
    localparam int DECAY_DIV = (DECAY_EPOCHS > 0) ? DECAY_EPOCHS : 1;

    typedef enum logic [1:0] {IDLE, PRESENT, UPDATE, FINISH} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     epochs_q;
    logic [15:0]     epoch_nxt;
    logic [CW-1:0]   settle_cnt;
    logic            accept;
    logic            last_sample;
    logic            last_epoch;
    logic            decay_now;

    assign accept      = start && !abort;
    assign epoch_nxt   = epoch_count + 16'd1;
    assign last_sample = (sample_idx == LAST_SAMPLE);
    assign last_epoch  = (epoch_nxt == epochs_q);
    assign decay_now   = (DECAY_EPOCHS > 0) && ((int'(epoch_nxt) % DECAY_DIV) == 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks every transition out of a busy state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (num_epochs != 16'd0) ? PRESENT : FINISH;
                end
            end
            PRESENT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == LAST_SETTLE) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_sample && last_epoch) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = PRESENT;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_idx        <= '0;
            epoch_count       <= '0;
            epochs_q          <= '0;
            settle_cnt        <= '0;
            mlp_training      <= 1'b0;
            mlp_learning_rate <= 0.0;
        end else begin
            mlp_training <= (state_nxt == UPDATE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        sample_idx  <= '0;
                        epoch_count <= '0;
                        settle_cnt  <= '0;
                        if (num_epochs != 16'd0) begin
                            epochs_q          <= num_epochs;
                            mlp_learning_rate <= lr_init;
                        end
                    end
                end
                PRESENT: begin
                    if (!abort) begin
                        settle_cnt <= (settle_cnt == LAST_SETTLE) ? '0 : settle_cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    if (!abort) begin
                        settle_cnt <= '0;
                        if (last_sample) begin
                            sample_idx  <= '0;
                            epoch_count <= epoch_nxt;
                            if (decay_now) begin
                                mlp_learning_rate <= mlp_learning_rate * 0.5;
                            end
                        end else begin
                            sample_idx <= sample_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
